// File: rtl/kmeans_k3n4_loader.sv
// Byte-serial point loader for the k=3, n=4 k-means core: assembles 4-dimension
// points, writes them to the d0..d3 memories, then pulses start. Optional: KMEANS_LOADER_CHECKSUM_EN.
module kmeans_k3n4_loader #(
  parameter int data_width               = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_req,
  input  logic                                s_valid,
  input  logic [data_width-1:0]               s_data,
  output logic                                s_ready,
  output logic                                mem_we,
  output logic [input_data_qty_bit_width-1:0] mem_addr,
  output logic [data_width-1:0]               mem_d0_wdata,
  output logic [data_width-1:0]               mem_d1_wdata,
  output logic [data_width-1:0]               mem_d2_wdata,
  output logic [data_width-1:0]               mem_d3_wdata,
  output logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [input_data_qty_bit_width:0]   points_loaded
`ifdef KMEANS_LOADER_CHECKSUM_EN
  ,
  output logic [data_width+input_data_qty_bit_width+1:0] checksum
`endif
);

  localparam int DW = data_width;
  localparam int AW = input_data_qty_bit_width;
  localparam logic [AW:0] LAST_PT = (AW+1)'(input_data_qty - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_START,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [DW-1:0]   h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
  logic [AW-1:0]   addr_cnt_q, addr_cnt_d;
  logic [AW:0]     points_q, points_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   wd0_q, wd0_d, wd1_q, wd1_d, wd2_q, wd2_d, wd3_q, wd3_d;
  logic            accept;

`ifdef KMEANS_LOADER_CHECKSUM_EN
  localparam int CW = DW + AW + 2;
  logic [CW-1:0]   csum_q, csum_d;
`endif

  assign s_ready = (state_q == S_LOAD);
  assign accept  = s_ready && s_valid;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    beat_d     = beat_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    addr_cnt_d = addr_cnt_q;
    points_d   = points_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    wd0_d      = wd0_q;
    wd1_d      = wd1_q;
    wd2_d      = wd2_q;
    wd3_d      = wd3_q;
`ifdef KMEANS_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_req) begin
          state_d    = S_LOAD;
          beat_d     = 2'd0;
          addr_cnt_d = '0;
          points_d   = '0;
`ifdef KMEANS_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LOAD: begin
        if (accept) begin
          beat_d = beat_q + 2'd1;
`ifdef KMEANS_LOADER_CHECKSUM_EN
          csum_d = csum_q + CW'(s_data);
`endif
          unique case (beat_q)
            2'd0: h0_d = s_data;
            2'd1: h1_d = s_data;
            2'd2: h2_d = s_data;
            default: begin
              // Beat 3 goes straight to the write port; the point is complete.
              mem_we_d   = 1'b1;
              mem_addr_d = addr_cnt_q;
              wd0_d      = h0_q;
              wd1_d      = h1_q;
              wd2_d      = h2_q;
              wd3_d      = s_data;
              addr_cnt_d = addr_cnt_q + AW'(1);
              points_d   = points_q + (AW+1)'(1);
              if (points_q == LAST_PT) state_d = S_FLUSH;
            end
          endcase
        end
      end
      S_FLUSH: state_d = S_START;
      S_START: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q    <= S_IDLE;
      beat_q     <= 2'd0;
      h0_q       <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
      addr_cnt_q <= '0;
      points_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wd0_q      <= '0;
      wd1_q      <= '0;
      wd2_q      <= '0;
      wd3_q      <= '0;
`ifdef KMEANS_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      addr_cnt_q <= addr_cnt_d;
      points_q   <= points_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wd0_q      <= wd0_d;
      wd1_q      <= wd1_d;
      wd2_q      <= wd2_d;
      wd3_q      <= wd3_d;
`ifdef KMEANS_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_d0_wdata  = wd0_q;
  assign mem_d1_wdata  = wd1_q;
  assign mem_d2_wdata  = wd2_q;
  assign mem_d3_wdata  = wd3_q;
  assign points_loaded = points_q;
  assign start         = (state_q == S_START);
  assign done          = (state_q == S_DONE);
  assign busy          = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_START);
`ifdef KMEANS_LOADER_CHECKSUM_EN
  assign checksum      = csum_q;
`endif

endmodule

// File: tb/tb_kmeans_k3n4_loader.sv
// Self-checking bench for kmeans_k3n4_loader: a qty=4 and a qty=256 instance
// share stimulus via a select, checked every cycle against a timestamp-based model.
module tb_kmeans_k3n4_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       load_req = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  always #5 clk = ~clk;

  logic       a_ready, a_we, a_start, a_busy, a_done;
  logic [7:0] a_addr, a_d0, a_d1, a_d2, a_d3;
  logic [8:0] a_pl;
  logic       b_ready, b_we, b_start, b_busy, b_done;
  logic [7:0] b_addr, b_d0, b_d1, b_d2, b_d3;
  logic [8:0] b_pl;
`ifdef KMEANS_LOADER_CHECKSUM_EN
  logic [17:0] a_cs, b_cs, checksum;
`endif

  kmeans_k3n4_loader #(.data_width(8), .input_data_qty_bit_width(8), .input_data_qty(4)) dut_a (
    .clk(clk), .rst(rst), .load_req(load_req && !sel), .s_valid(s_valid && !sel), .s_data(s_data),
    .s_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr),
    .mem_d0_wdata(a_d0), .mem_d1_wdata(a_d1), .mem_d2_wdata(a_d2), .mem_d3_wdata(a_d3),
    .start(a_start), .busy(a_busy), .done(a_done), .points_loaded(a_pl)
`ifdef KMEANS_LOADER_CHECKSUM_EN
    , .checksum(a_cs)
`endif
  );

  kmeans_k3n4_loader #(.data_width(8), .input_data_qty_bit_width(8), .input_data_qty(256)) dut_b (
    .clk(clk), .rst(rst), .load_req(load_req && sel), .s_valid(s_valid && sel), .s_data(s_data),
    .s_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr),
    .mem_d0_wdata(b_d0), .mem_d1_wdata(b_d1), .mem_d2_wdata(b_d2), .mem_d3_wdata(b_d3),
    .start(b_start), .busy(b_busy), .done(b_done), .points_loaded(b_pl)
`ifdef KMEANS_LOADER_CHECKSUM_EN
    , .checksum(b_cs)
`endif
  );

  wire       s_ready = sel ? b_ready : a_ready;
  wire       mem_we  = sel ? b_we    : a_we;
  wire       start   = sel ? b_start : a_start;
  wire       busy    = sel ? b_busy  : a_busy;
  wire       done    = sel ? b_done  : a_done;
  wire [7:0] addr    = sel ? b_addr  : a_addr;
  wire [7:0] d0      = sel ? b_d0    : a_d0;
  wire [7:0] d1      = sel ? b_d1    : a_d1;
  wire [7:0] d2      = sel ? b_d2    : a_d2;
  wire [7:0] d3      = sel ? b_d3    : a_d3;
  wire [8:0] pl      = sel ? b_pl    : a_pl;
`ifdef KMEANS_LOADER_CHECKSUM_EN
  assign checksum = sel ? b_cs : a_cs;
`endif

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
    end
  endtask

  // Reference model: timestamps of the final accepted beat drive the tail behaviour.
  int          cyc = 0;
  bit          loading = 0;
  int          t_final = -100;
  int          pt = 0;
  logic [7:0]  cur[$];
  logic        e_ready = 0, e_we = 0, e_start = 0, e_busy = 0, e_done = 0;
  logic [7:0]  e_addr = 0;
  logic [7:0]  e_wd[4] = '{default: 8'h00};
  logic [17:0] e_cs = 0;

  always @(posedge clk) begin
    int qty;
    qty = sel ? 256 : 4;
    cyc++;
    if (!rst) begin
      loading = 0; t_final = -100; pt = 0; cur.delete();
      e_we = 0; e_addr = 0; e_wd = '{default: 8'h00}; e_cs = 0;
    end else begin
      e_we = 0;
      if (loading) begin
        if (s_valid) begin
          cur.push_back(s_data);
          e_cs = e_cs + 18'(s_data);
          if (cur.size() == 4) begin
            e_we = 1;
            e_addr = 8'(pt % 256);
            for (int k = 0; k < 4; k++) e_wd[k] = cur[k];
            pt++;
            cur.delete();
            if (pt == qty) begin loading = 0; t_final = cyc - 1; end
          end
        end
      end else if (load_req && (cyc - 1 != t_final + 1) && (cyc - 1 != t_final + 2)) begin
        loading = 1; t_final = -100; pt = 0; e_cs = 0;
      end
    end
    e_ready = loading;
    e_start = (cyc == t_final + 2);
    e_busy  = loading || (cyc == t_final + 1) || e_start;
    e_done  = !loading && (t_final >= 0) && (cyc >= t_final + 3);
  end

  bit chk_en = 0;
  typedef struct { logic [7:0] addr; logic [7:0] d[4]; int c; } wr_t;
  wr_t wq[$];
  int  n_start = 0;
  int  start_cyc = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", s_ready, e_ready);
      check("mem_we", mem_we, e_we);
      check("mem_addr", addr, e_addr);
      check("wd0", d0, e_wd[0]);
      check("wd1", d1, e_wd[1]);
      check("wd2", d2, e_wd[2]);
      check("wd3", d3, e_wd[3]);
      check("start", start, e_start);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("points_loaded", pl, pt);
`ifdef KMEANS_LOADER_CHECKSUM_EN
      check("checksum", checksum, e_cs);
`endif
    end
    if (mem_we === 1'b1) wq.push_back('{addr, '{d0, d1, d2, d3}, cyc});
    if (start === 1'b1) begin n_start++; start_cyc = cyc; end
  end

  int acc_cyc = 0;

  task automatic start_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input int gap, input bit noise);
    int g = 0;
    s_valid = 1'b1; s_data = d;
    if (noise) load_req = 1'($urandom_range(0, 1));
    while (!s_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
    s_valid = 1'b0; load_req = 1'b0; s_data = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 60) begin @(posedge clk); #1; g++; end
    check("done_timeout", done, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b3q[$];
    int last_b3;
    int ns0;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; chk_en = 1; rst = 1'b1;

    // Idle with garbage traffic: nothing may be written.
    s_valid = 1'b1; s_data = 8'hFF;
    repeat (10) begin @(posedge clk); #1; end
    s_valid = 1'b0;
    check("idle_no_write", wq.size(), 0);
    check("idle_ready", s_ready, 0);

    // qty=4, continuous stream 0x00..0x0F.
    start_load();
    check("ready_after_req", s_ready, 1);
    for (int i = 0; i < 16; i++) beat(8'(i), 0, 0);
    last_b3 = acc_cyc;
    wait_done();
    check("cont_writes", wq.size(), 4);
    for (int p = 0; p < 4 && p < wq.size(); p++) begin
      check("cont_addr", wq[p].addr, p);
      for (int k = 0; k < 4; k++) check("cont_data", wq[p].d[k], 4 * p + k);
    end
    check("start_once", n_start, 1);
    check("start_lat", start_cyc - last_b3, 2);
    check("pl_4", pl, 4);
    check("done_4", done, 1);
`ifdef KMEANS_LOADER_CHECKSUM_EN
    check("checksum_120", checksum, 120);
`endif

    // Same stream with 3-cycle gaps after every beat.
    wq.delete();
    start_load();
`ifdef KMEANS_LOADER_CHECKSUM_EN
    check("checksum_clear", checksum, 0);
`endif
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), 3, 0);
      if (i % 4 == 3) b3q.push_back(acc_cyc);
    end
    wait_done();
    check("gap_writes", wq.size(), 4);
    for (int p = 0; p < 4 && p < wq.size(); p++) begin
      check("gap_addr", wq[p].addr, p);
      for (int k = 0; k < 4; k++) check("gap_data", wq[p].d[k], 4 * p + k);
      check("gap_we_lat", wq[p].c - b3q[p], 1);
    end

    // Randomized loads with gaps and ignored load_req noise.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      start_load();
      for (int i = 0; i < 16; i++) beat(8'($urandom), $urandom_range(0, 2), 1);
      wait_done();
    end

    // Reset mid-load, then reload.
    start_load();
    for (int i = 0; i < 6; i++) beat(8'($urandom), 0, 0);
    ns0 = n_start;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("abort_no_start", n_start, ns0);
    check("abort_not_done", done, 0);
    wq.delete();
    start_load();
    for (int i = 0; i < 16; i++) beat(8'($urandom), 0, 0);
    wait_done();
    check("reload_writes", wq.size(), 4);
    if (wq.size() > 0) check("reload_first_addr", wq[0].addr, 0);

    // Full-range wrap on the qty=256 instance.
    rst = 1'b0;
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    wq.delete();
    ns0 = n_start;
    start_load();
    for (int i = 0; i < 1024; i++) beat(8'($urandom), 0, 0);
    last_b3 = acc_cyc;
    wait_done();
    check("wrap_writes", wq.size(), 256);
    if (wq.size() > 0) check("wrap_last_addr", wq[wq.size() - 1].addr, 255);
    check("wrap_pl_256", pl, 256);
    check("wrap_start", n_start, ns0 + 1);
    check("wrap_start_lat", start_cyc - last_b3, 2);

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
